// File: rtl/ili_spi_if.sv
// Byte handshake between the ILI9341 init/pixel controllers and the SPI
// transmitter. A controller presents data/dc with send. The byte is taken
// on a clock edge where send and ready are both high.
interface ili_spi_if #(
    parameter int DW = 8
);
    logic [DW-1:0] data;
    logic          dc;
    logic          send;
    logic          ready;
    logic          busy;
    logic          byte_done;

    modport master (
        output data,
        output dc,
        output send,
        input  ready,
        input  busy,
        input  byte_done
    );

    modport slave (
        input  data,
        input  dc,
        input  send,
        output ready,
        output busy,
        output byte_done
    );
endinterface

// File: rtl/ili_spi_tx.sv
// ILI9341 4-wire SPI transmitter (mode 0, MSB first).
// Each accepted byte carries its own D/C flag. A one-deep holding buffer
// lets the next byte chain onto the current one with CS held low. After the
// last byte of a frame, CS stays low for one half-period. It then stays high
// for CS_GAP cycles before the next byte is accepted.
// Every output is a flop. Its next value comes from the same next-state
// logic that drives the FSM, so outputs line up with the state they
// describe.
module ili_spi_tx #(
    parameter int DW      = 8,
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 4
) (
    input  logic      clk,
    input  logic      rst,
    ili_spi_if.slave  bus,
    output logic      spi_cs,
    output logic      spi_sck,
    output logic      spi_mosi,
    output logic      spi_dc
);

    localparam int HW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW   = (DW > 1) ? $clog2(DW) : 1;
    localparam int GMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int GW   = (GMAX > 1) ? $clog2(GMAX) : 1;

    localparam logic [HW-1:0] H_LAST    = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] B_LAST    = BW'(DW - 1);
    localparam logic [GW-1:0] HOLD_LAST = GW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t        state_r,     state_nx_s;
    logic [HW-1:0] hcnt_r,      hcnt_nx_s;
    logic [BW-1:0] bcnt_r,      bcnt_nx_s;
    logic [GW-1:0] gcnt_r,      gcnt_nx_s;
    logic [DW-1:0] shreg_r,     shreg_nx_s;
    logic [DW-1:0] buf_data_r,  buf_data_nx_s;
    logic          buf_dc_r,    buf_dc_nx_s;
    logic          buf_valid_r, buf_valid_nx_s;
    logic          cs_r,        cs_nx_s;
    logic          sck_r,       sck_nx_s;
    logic          mosi_r,      mosi_nx_s;
    logic          dc_r,        dc_nx_s;
    logic          ready_r,     ready_nx_s;
    logic          busy_r,      busy_nx_s;
    logic          bdone_r,     bdone_nx_s;

    logic          accept_s;
    logic [DW-1:0] shifted_s;

    assign accept_s  = bus.send & ready_r;
    assign shifted_s = shreg_r << 1;

    assign bus.ready     = ready_r;
    assign bus.busy      = busy_r;
    assign bus.byte_done = bdone_r;
    assign spi_cs        = cs_r;
    assign spi_sck       = sck_r;
    assign spi_mosi      = mosi_r;
    assign spi_dc        = dc_r;

    // Next-state, datapath and output look-ahead for the frame sequencer.
    always_comb begin
        state_nx_s     = state_r;
        hcnt_nx_s      = hcnt_r;
        bcnt_nx_s      = bcnt_r;
        gcnt_nx_s      = gcnt_r;
        shreg_nx_s     = shreg_r;
        buf_data_nx_s  = buf_data_r;
        buf_dc_nx_s    = buf_dc_r;
        buf_valid_nx_s = buf_valid_r;
        cs_nx_s        = cs_r;
        sck_nx_s       = sck_r;
        mosi_nx_s      = mosi_r;
        dc_nx_s        = dc_r;

        case (state_r)
            ST_IDLE: begin
                cs_nx_s   = 1'b1;
                sck_nx_s  = 1'b0;
                mosi_nx_s = 1'b0;
                hcnt_nx_s = '0;
                bcnt_nx_s = '0;
                gcnt_nx_s = '0;
                if (accept_s) begin
                    state_nx_s = ST_SHIFT;
                    shreg_nx_s = bus.data;
                    dc_nx_s    = bus.dc;
                    cs_nx_s    = 1'b0;
                    mosi_nx_s  = bus.data[DW-1];
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                // ready is low while the buffer is full, so a write here never overwrites
                if (accept_s) begin
                    buf_valid_nx_s = 1'b1;
                    buf_data_nx_s  = bus.data;
                    buf_dc_nx_s    = bus.dc;
                end else begin
                    buf_valid_nx_s = buf_valid_r;
                end

                if (hcnt_r != H_LAST) begin
                    hcnt_nx_s = hcnt_r + HW'(1);
                end else begin
                    hcnt_nx_s = '0;
                    if (!sck_r) begin
                        sck_nx_s = 1'b1;
                    end else if (bcnt_r != B_LAST) begin
                        sck_nx_s   = 1'b0;
                        bcnt_nx_s  = bcnt_r + BW'(1);
                        shreg_nx_s = shifted_s;
                        mosi_nx_s  = shifted_s[DW-1];
                    end else if (buf_valid_r) begin
                        // byte boundary: chain the buffered byte, CS stays low
                        sck_nx_s       = 1'b0;
                        bcnt_nx_s      = '0;
                        shreg_nx_s     = buf_data_r;
                        mosi_nx_s      = buf_data_r[DW-1];
                        dc_nx_s        = buf_dc_r;
                        buf_valid_nx_s = 1'b0;
                    end else if (accept_s) begin
                        // byte boundary: a byte offered right now bypasses the buffer
                        sck_nx_s       = 1'b0;
                        bcnt_nx_s      = '0;
                        shreg_nx_s     = bus.data;
                        mosi_nx_s      = bus.data[DW-1];
                        dc_nx_s        = bus.dc;
                        buf_valid_nx_s = 1'b0;
                    end else begin
                        state_nx_s = ST_HOLD;
                        sck_nx_s   = 1'b0;
                        gcnt_nx_s  = '0;
                    end
                end
            end

            ST_HOLD: begin
                sck_nx_s = 1'b0;
                if (gcnt_r == HOLD_LAST) begin
                    state_nx_s = ST_GAP;
                    cs_nx_s    = 1'b1;
                    mosi_nx_s  = 1'b0;
                    gcnt_nx_s  = '0;
                end else begin
                    gcnt_nx_s = gcnt_r + GW'(1);
                end
            end

            ST_GAP: begin
                cs_nx_s   = 1'b1;
                sck_nx_s  = 1'b0;
                mosi_nx_s = 1'b0;
                if (gcnt_r == GAP_LAST) begin
                    state_nx_s = ST_IDLE;
                    gcnt_nx_s  = '0;
                end else begin
                    gcnt_nx_s = gcnt_r + GW'(1);
                end
            end

            default: begin
                state_nx_s     = ST_IDLE;
                cs_nx_s        = 1'b1;
                sck_nx_s       = 1'b0;
                mosi_nx_s      = 1'b0;
                buf_valid_nx_s = 1'b0;
            end
        endcase

        ready_nx_s = (state_nx_s == ST_IDLE) ||
                     ((state_nx_s == ST_SHIFT) && !buf_valid_nx_s);
        busy_nx_s  = (state_nx_s != ST_IDLE);
        bdone_nx_s = (state_nx_s == ST_SHIFT) && sck_nx_s &&
                     (hcnt_nx_s == H_LAST) && (bcnt_nx_s == B_LAST);
    end

    // State, datapath and output registers; reset aborts any byte in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            hcnt_r      <= '0;
            bcnt_r      <= '0;
            gcnt_r      <= '0;
            shreg_r     <= '0;
            buf_data_r  <= '0;
            buf_dc_r    <= 1'b0;
            buf_valid_r <= 1'b0;
            cs_r        <= 1'b1;
            sck_r       <= 1'b0;
            mosi_r      <= 1'b0;
            dc_r        <= 1'b1;
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
            bdone_r     <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            hcnt_r      <= hcnt_nx_s;
            bcnt_r      <= bcnt_nx_s;
            gcnt_r      <= gcnt_nx_s;
            shreg_r     <= shreg_nx_s;
            buf_data_r  <= buf_data_nx_s;
            buf_dc_r    <= buf_dc_nx_s;
            buf_valid_r <= buf_valid_nx_s;
            cs_r        <= cs_nx_s;
            sck_r       <= sck_nx_s;
            mosi_r      <= mosi_nx_s;
            dc_r        <= dc_nx_s;
            ready_r     <= ready_nx_s;
            busy_r      <= busy_nx_s;
            bdone_r     <= bdone_nx_s;
        end
    end

endmodule

// File: tb/tb_ili_spi_tx.sv
// Bench for ili_spi_tx.
// DUT A uses CLK_DIV=2 and DUT B uses CLK_DIV=1. Accepted bytes are pushed
// to a per-DUT scoreboard. A monitor rebuilds each byte from MOSI at the
// rising edges of SCK, then compares it with the scoreboard entry.
module tb_ili_spi_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ili_spi_if #(.DW(8)) bus_a ();
    ili_spi_if #(.DW(8)) bus_b ();
    logic spi_cs_a, spi_sck_a, spi_mosi_a, spi_dc_a;
    logic spi_cs_b, spi_sck_b, spi_mosi_b, spi_dc_b;

    ili_spi_tx #(.DW(8), .CLK_DIV(2), .CS_GAP(4)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .spi_cs(spi_cs_a), .spi_sck(spi_sck_a), .spi_mosi(spi_mosi_a), .spi_dc(spi_dc_a)
    );

    ili_spi_tx #(.DW(8), .CLK_DIV(1), .CS_GAP(4)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .spi_cs(spi_cs_b), .spi_sck(spi_sck_b), .spi_mosi(spi_mosi_b), .spi_dc(spi_dc_b)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [8:0] sb_a[$];
    logic [8:0] sb_b[$];
    logic [8:0] feed_q[$];
    int bytes_a = 0;
    int bytes_b = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor A: rebuild bytes at SCK rises and compare {dc,byte} with the scoreboard
    initial begin
        logic [7:0] sh;
        int cnt;
        logic prev;
        cnt = 0; prev = 1'b0; sh = 8'h00;
        forever begin
            @(negedge clk);
            if (spi_cs_a !== 1'b0) begin
                cnt = 0;
            end else if (spi_sck_a === 1'b1 && prev === 1'b0) begin
                sh = {sh[6:0], spi_mosi_a};
                cnt++;
                if (cnt == 8) begin
                    cnt = 0;
                    bytes_a++;
                    if (sb_a.size() == 0) check("a_unexpected_byte", {23'd0, spi_dc_a, sh}, 32'hFFFF_FFFF);
                    else check("a_byte", {23'd0, spi_dc_a, sh}, {23'd0, sb_a.pop_front()});
                end
            end
            prev = spi_sck_a;
        end
    end

    // Monitor B: same as monitor A, for the CLK_DIV=1 instance
    initial begin
        logic [7:0] sh;
        int cnt;
        logic prev;
        cnt = 0; prev = 1'b0; sh = 8'h00;
        forever begin
            @(negedge clk);
            if (spi_cs_b !== 1'b0) begin
                cnt = 0;
            end else if (spi_sck_b === 1'b1 && prev === 1'b0) begin
                sh = {sh[6:0], spi_mosi_b};
                cnt++;
                if (cnt == 8) begin
                    cnt = 0;
                    bytes_b++;
                    if (sb_b.size() == 0) check("b_unexpected_byte", {23'd0, spi_dc_b, sh}, 32'hFFFF_FFFF);
                    else check("b_byte", {23'd0, spi_dc_b, sh}, {23'd0, sb_b.pop_front()});
                end
            end
            prev = spi_sck_b;
        end
    end

    // Feed feed_q into DUT A and measure one frame. Cycle k=1 is the cycle after the first accept.
    // Bytes after the first are not offered before cycle gap_k.
    task automatic run_a(input int gap_k, input int limit,
                         output int cs_low, output int n_bd, output int bd_gap, output int first_bd,
                         output int ready_at, output int dc_bad, output int stall);
        int n_acc;
        int last_bd;
        bit pend;
        logic prev_dc;
        cs_low = 0; n_bd = 0; bd_gap = 0; first_bd = 0; ready_at = -1;
        dc_bad = 0; stall = 0; n_acc = 0; last_bd = 0;
        prev_dc = spi_dc_a;
        if (feed_q.size() > 0) begin
            bus_a.send = 1'b1;
            {bus_a.dc, bus_a.data} = feed_q[0];
        end else begin
            bus_a.send = 1'b0;
        end
        pend = bus_a.send && bus_a.ready;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (pend) begin
                sb_a.push_back(feed_q.pop_front());
                n_acc++;
            end
            if (feed_q.size() > 0 && (n_acc == 0 || k >= gap_k)) begin
                bus_a.send = 1'b1;
                {bus_a.dc, bus_a.data} = feed_q[0];
            end else begin
                bus_a.send = 1'b0;
            end
            if (spi_cs_a === 1'b0) cs_low++;
            if (bus_a.byte_done === 1'b1) begin
                n_bd++;
                if (n_bd == 1) first_bd = k;
                else bd_gap = k - last_bd;
                last_bd = k;
            end
            if (spi_cs_a === 1'b0 && spi_dc_a !== prev_dc && spi_sck_a !== 1'b0) dc_bad++;
            prev_dc = spi_dc_a;
            if (bus_a.send && !bus_a.ready) stall++;
            if (feed_q.size() == 0 && !bus_a.send && bus_a.ready === 1'b1 && bus_a.busy === 1'b0) begin
                ready_at = k;
                break;
            end
            pend = bus_a.send && bus_a.ready;
        end
        bus_a.send = 1'b0;
        feed_q.delete();
    endtask

    initial begin
        int cs_low, n_bd, bd_gap, first_bd, ready_at, dc_bad, stall, rises, tog_bad;
        logic prev;
        bus_a.send = 1'b0; bus_a.data = 8'h00; bus_a.dc = 1'b0;
        bus_b.send = 1'b0; bus_b.data = 8'h00; bus_b.dc = 1'b0;

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cs",    {31'd0, spi_cs_a},        32'd1);
        check("rst_sck",   {31'd0, spi_sck_a},       32'd0);
        check("rst_mosi",  {31'd0, spi_mosi_a},      32'd0);
        check("rst_dc",    {31'd0, spi_dc_a},        32'd1);
        check("rst_busy",  {31'd0, bus_a.busy},      32'd0);
        check("rst_bdone", {31'd0, bus_a.byte_done}, 32'd0);
        check("rst_ready", {31'd0, bus_a.ready},     32'd1);
        rst = 1'b0;
        @(negedge clk);

        // 1: single command byte 0xA5
        feed_q.push_back({1'b0, 8'hA5});
        run_a(0, 200, cs_low, n_bd, bd_gap, first_bd, ready_at, dc_bad, stall);
        check("t1_cs_low",   cs_low,   32'd34);
        check("t1_bdone",    n_bd,     32'd1);
        check("t1_ready_at", ready_at, 32'd39);
        check("t1_first_bd", first_bd, 32'd32);
        repeat (2) @(negedge clk);

        // 2: command then parameter streamed under one CS window
        feed_q.push_back({1'b0, 8'h2A});
        feed_q.push_back({1'b1, 8'h00});
        run_a(0, 300, cs_low, n_bd, bd_gap, first_bd, ready_at, dc_bad, stall);
        check("t2_cs_low",   cs_low,   32'd66);
        check("t2_bdone",    n_bd,     32'd2);
        check("t2_bd_gap",   bd_gap,   32'd32);
        check("t2_dc_bad",   dc_bad,   32'd0);
        check("t2_ready_at", ready_at, 32'd71);
        repeat (2) @(negedge clk);

        // 3: third byte held off while the buffer is full
        feed_q.push_back({1'b0, 8'h11});
        feed_q.push_back({1'b1, 8'h22});
        feed_q.push_back({1'b1, 8'h33});
        run_a(0, 400, cs_low, n_bd, bd_gap, first_bd, ready_at, dc_bad, stall);
        check("t3_stall",    stall,    32'd31);
        check("t3_cs_low",   cs_low,   32'd98);
        check("t3_bdone",    n_bd,     32'd3);
        check("t3_ready_at", ready_at, 32'd103);
        check("t3_sb_empty", sb_a.size(), 32'd0);
        repeat (2) @(negedge clk);

        // 4: reset after three bits of 0x96, then 0x3C transmits cleanly
        bus_a.send = 1'b1; bus_a.data = 8'h96; bus_a.dc = 1'b0;
        @(negedge clk);
        bus_a.send = 1'b0;
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_cs",    {31'd0, spi_cs_a},   32'd1);
        check("t4_sck",   {31'd0, spi_sck_a},  32'd0);
        check("t4_mosi",  {31'd0, spi_mosi_a}, 32'd0);
        check("t4_dc",    {31'd0, spi_dc_a},   32'd1);
        check("t4_busy",  {31'd0, bus_a.busy}, 32'd0);
        check("t4_ready", {31'd0, bus_a.ready}, 32'd1);
        @(negedge clk);
        feed_q.push_back({1'b1, 8'h3C});
        run_a(0, 200, cs_low, n_bd, bd_gap, first_bd, ready_at, dc_bad, stall);
        check("t4_cs_low",   cs_low,   32'd34);
        check("t4_ready_at", ready_at, 32'd39);
        repeat (2) @(negedge clk);

        // 6: second byte offered exactly on the boundary cycle, buffer empty
        feed_q.push_back({1'b0, 8'h5A});
        feed_q.push_back({1'b1, 8'hC3});
        run_a(32, 300, cs_low, n_bd, bd_gap, first_bd, ready_at, dc_bad, stall);
        check("t6_first_bd", first_bd, 32'd32);
        check("t6_cs_low",   cs_low,   32'd66);
        check("t6_bd_gap",   bd_gap,   32'd32);
        check("t6_ready_at", ready_at, 32'd71);

        // 5: CLK_DIV=1 instance sends 0xFF
        bus_b.send = 1'b1; bus_b.data = 8'hFF; bus_b.dc = 1'b1;
        sb_b.push_back({1'b1, 8'hFF});
        @(negedge clk);
        bus_b.send = 1'b0;
        cs_low = 0; rises = 0; tog_bad = 0; ready_at = -1; prev = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (k > 1) @(negedge clk);
            if (spi_cs_b === 1'b0) cs_low++;
            if (spi_sck_b === 1'b1 && prev === 1'b0) rises++;
            if (k <= 16 && spi_sck_b !== ((k % 2) == 0)) tog_bad++;
            prev = spi_sck_b;
            if (bus_b.ready === 1'b1 && bus_b.busy === 1'b0) begin
                ready_at = k;
                break;
            end
        end
        check("t5_cs_low",   cs_low,   32'd17);
        check("t5_rises",    rises,    32'd8);
        check("t5_toggle",   tog_bad,  32'd0);
        check("t5_ready_at", ready_at, 32'd22);

        repeat (4) @(negedge clk);
        check("end_sb_a",    sb_a.size(), 32'd0);
        check("end_sb_b",    sb_b.size(), 32'd0);
        check("end_bytes_a", bytes_a,     32'd9);
        check("end_bytes_b", bytes_b,     32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
